// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, defaults and the stored entry type for the fetch-side instruction queue.
package inst_fetch_queue_pkg;

  localparam int FETCH_Q_DEPTH = 4;
  localparam int FETCH_Q_AW    = 2;
  localparam int INST_ADDR_W   = 32;
  localparam int INST_W        = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fq_mem.sv
// Queue storage: DEPTH x 64-bit register array, one synchronous write port, one async read port.
module fq_mem
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int AW    = FETCH_Q_AW
) (
  input  logic         Clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem [DEPTH];

  // NOTE: storage has no reset; occupancy in the control logic decides what is valid.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between the PC/ROM fetch stage and ID: buffers {pc, inst} pairs, valid/ready toward ID.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int AW    = FETCH_Q_AW
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ce_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0]      inst_i,
  input  logic                   flush_i,
  output logic                   stall_req_o,
  output logic                   id_valid_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  input  logic                   id_ready_i,
  output logic [AW:0]            count_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW:0]   count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          full;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // Full comes from the count register only, so stall never depends combinationally on ce_i/id_ready_i.
  assign full  = (count_q == FULL_CNT);
  assign push  = ce_i & ~full & ~flush_i;
  assign pop   = id_valid_o & id_ready_i & ~flush_i;

  assign wr_entry = '{pc: pc_i, inst: inst_i};

  fq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .Clk   (Clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst || flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign stall_req_o = full;
  assign id_valid_o  = (count_q != '0);
  assign id_pc_o     = id_valid_o ? head.pc   : ZERO_WORD;
  assign id_inst_o   = id_valid_o ? head.inst : ZERO_WORD;
  assign count_o     = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: table of per-cycle vectors plus hand-written corner sequences.
module tb_inst_fetch_queue;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        flush;
    logic        ready;
    logic [2:0]  exp_count;
    logic        exp_valid;
    logic        exp_stall;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_queue dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .ce_i        (ce_i),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .id_valid_o  (id_valid_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .id_ready_i  (id_ready_i),
    .count_o     (count_o)
  );

  always #5 Clk = ~Clk;

  // Instruction word the fake ROM returns for a given pc.
  function automatic logic [31:0] rom(input logic [31:0] pc);
    return 32'hA5A5_0000 ^ {pc[15:0], pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic ce, input logic [31:0] pc,
                     input logic flush, input logic ready, input logic [2:0] exp_count,
                     input logic exp_valid, input logic exp_stall, input logic [31:0] exp_pc);
    vec_t v;
    v.name = name; v.rst = rst; v.ce = ce; v.pc = pc; v.flush = flush; v.ready = ready;
    v.exp_count = exp_count; v.exp_valid = exp_valid; v.exp_stall = exp_stall; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ce, input logic [31:0] pc,
                       input logic flush, input logic ready);
    Rst = rst; ce_i = ce; pc_i = pc; inst_i = rom(pc); flush_i = flush; id_ready_i = ready;
  endtask

  task automatic check_outputs(input string name, input logic [2:0] c, input logic v,
                               input logic s, input logic [31:0] p);
    check({name, ".count"}, 32'(count_o), 32'(c));
    check({name, ".valid"}, 32'(id_valid_o), 32'(v));
    check({name, ".stall"}, 32'(stall_req_o), 32'(s));
    check({name, ".pc"}, id_pc_o, p);
    check({name, ".inst"}, id_inst_o, v ? rom(p) : 32'h0);
  endtask

  initial begin
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);

    // Reset held two cycles with fetch enabled.
    add("rst0", 1, 1, 32'h100, 0, 0, 0, 0, 0, 32'h0);
    add("rst1", 1, 1, 32'h104, 0, 0, 0, 0, 0, 32'h0);
    // Fill to full; pc 16 is refused.
    add("fill0", 0, 1, 32'd0,  0, 0, 1, 1, 0, 32'd0);
    add("fill1", 0, 1, 32'd4,  0, 0, 2, 1, 0, 32'd0);
    add("fill2", 0, 1, 32'd8,  0, 0, 3, 1, 0, 32'd0);
    add("fill3", 0, 1, 32'd12, 0, 0, 4, 1, 1, 32'd0);
    add("fill4", 0, 1, 32'd16, 0, 0, 4, 1, 1, 32'd0);
    // Drain in order.
    add("drain0", 0, 0, 32'd0, 0, 1, 3, 1, 0, 32'd4);
    add("drain1", 0, 0, 32'd0, 0, 1, 2, 1, 0, 32'd8);
    add("drain2", 0, 0, 32'd0, 0, 1, 1, 1, 0, 32'd12);
    add("drain3", 0, 0, 32'd0, 0, 1, 0, 0, 0, 32'd0);
    add("drain4", 0, 0, 32'd0, 0, 1, 0, 0, 0, 32'd0);
    // Stream: occupancy stays at 1, head is always the latest fetch; pointers wrap 5 times.
    for (int k = 0; k < 20; k++)
      add($sformatf("stream%0d", k), 0, 1, 32'h200 + 32'(4*k), 0, 1, 1, 1, 0, 32'h200 + 32'(4*k));
    add("stream_end", 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    // Flush with 3 queued; the flush-cycle fetch must not be stored.
    add("fl_q0", 0, 1, 32'h300, 0, 0, 1, 1, 0, 32'h300);
    add("fl_q1", 0, 1, 32'h304, 0, 0, 2, 1, 0, 32'h300);
    add("fl_q2", 0, 1, 32'h308, 0, 0, 3, 1, 0, 32'h300);
    add("flush", 0, 1, 32'h30C, 1, 1, 0, 0, 0, 32'h0);
    add("fl_after", 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    // Full + pop same cycle: push refused, held pc accepted next cycle.
    add("fp_q0", 0, 1, 32'h400, 0, 0, 1, 1, 0, 32'h400);
    add("fp_q1", 0, 1, 32'h404, 0, 0, 2, 1, 0, 32'h400);
    add("fp_q2", 0, 1, 32'h408, 0, 0, 3, 1, 0, 32'h400);
    add("fp_q3", 0, 1, 32'h40C, 0, 0, 4, 1, 1, 32'h400);
    add("fp_pop", 0, 1, 32'h410, 0, 1, 3, 1, 0, 32'h404);
    add("fp_push", 0, 1, 32'h410, 0, 0, 4, 1, 1, 32'h404);
    add("fp_d0", 0, 0, 32'h0, 0, 1, 3, 1, 0, 32'h408);
    add("fp_d1", 0, 0, 32'h0, 0, 1, 2, 1, 0, 32'h40C);
    add("fp_d2", 0, 0, 32'h0, 0, 1, 1, 1, 0, 32'h410);
    add("fp_d3", 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    // Reset mid-operation behaves like flush.
    add("mr_q0", 0, 1, 32'h500, 0, 0, 1, 1, 0, 32'h500);
    add("mr_q1", 0, 1, 32'h504, 0, 0, 2, 1, 0, 32'h500);
    add("mr_rst", 1, 1, 32'h508, 0, 1, 0, 0, 0, 32'h0);
    add("mr_q2", 0, 1, 32'h600, 0, 0, 1, 1, 0, 32'h600);
    add("mr_pop", 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].flush, vecs[i].ready);
      @(posedge Clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_count, vecs[i].exp_valid,
                    vecs[i].exp_stall, vecs[i].exp_pc);
    end

    // Empty + push + ready: no bypass, head appears only after the edge.
    @(negedge Clk);
    drive(1'b0, 1'b1, 32'h700, 1'b0, 1'b1);
    #1;
    check("nobypass.valid_pre", 32'(id_valid_o), 32'd0);
    check("nobypass.pc_pre", id_pc_o, 32'h0);
    @(posedge Clk);
    #1;
    check_outputs("nobypass.post", 3'd1, 1'b1, 1'b0, 32'h700);

    // Fill to full, then raise ready mid-cycle: stall must not react before the edge.
    for (int k = 1; k < 4; k++) begin
      @(negedge Clk);
      drive(1'b0, 1'b1, 32'h700 + 32'(4*k), 1'b0, 1'b0);
    end
    @(negedge Clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_outputs("stallpath.full", 3'd4, 1'b1, 1'b1, 32'h700);
    id_ready_i = 1'b1;
    ce_i = 1'b1;
    #1;
    check("stallpath.stall_pre", 32'(stall_req_o), 32'd1);
    @(posedge Clk);
    #1;
    check_outputs("stallpath.post", 3'd3, 1'b1, 1'b0, 32'h704);

    @(negedge Clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    check_outputs("final_rst", 3'd0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
